// File: rtl/u409_pkg.sv
// Shared types and defaults for the U409 bus-cycle watchdog: FSM states,
// ERR_CODE values, default response budgets and decode helpers.
`timescale 1ns/100ps
package u409_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        COUNT,
        TEA,
        HOLD
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_UNMAPPED = 3'd1,
        ERR_CONFLICT = 3'd2,
        ERR_ROM      = 3'd3,
        ERR_CIA      = 3'd4,
        ERR_AGNUS    = 3'd5,
        ERR_LOCAL    = 3'd6
    } err_code_t;

    localparam int DEF_CTR_W        = 8;
    localparam int DEF_ROM_BUDGET   = 64;
    localparam int DEF_AGNUS_BUDGET = 255;
    localparam int DEF_LOCAL_BUDGET = 255;
    localparam int DEF_CIA_BUDGET   = 24;
    localparam int DEF_UNMAP_DELAY  = 2;
    localparam int DEF_HOLDOFF      = 2;

    // Cause code for a decode: one flag names its space, none or several are errors.
    function automatic err_code_t classify(input logic rom, input logic cia,
                                           input logic agnus, input logic lcl);
        case ({rom, cia, agnus, lcl})
            4'b1000: return ERR_ROM;
            4'b0100: return ERR_CIA;
            4'b0010: return ERR_AGNUS;
            4'b0001: return ERR_LOCAL;
            4'b0000: return ERR_UNMAPPED;
            default: return ERR_CONFLICT;
        endcase
    endfunction

    function automatic bit param_in_range(input int value, input int ctr_w);
        return (value >= 1) && (longint'(value) <= ((longint'(1) << ctr_w) - 1));
    endfunction

endpackage

// File: rtl/u409_bus_watchdog_if.sv
// Bus-side signals seen by the watchdog: transfer start, decode flags in,
// registered bus-error level and status out.
`timescale 1ns/100ps
interface u409_bus_watchdog_if;

    logic       nTS;
    logic       ROM_SPACE;
    logic       CIA_SPACE;
    logic       AGNUS_SPACE;
    logic       LOCAL_SPACE;
    logic       nTEA;
    logic       CYCLE_ACTIVE;
    logic [2:0] ERR_CODE;

    // CPU and address-decode side
    modport master (
        output nTS, ROM_SPACE, CIA_SPACE, AGNUS_SPACE, LOCAL_SPACE,
        input  nTEA, CYCLE_ACTIVE, ERR_CODE
    );

    // Watchdog side
    modport slave (
        input  nTS, ROM_SPACE, CIA_SPACE, AGNUS_SPACE, LOCAL_SPACE,
        output nTEA, CYCLE_ACTIVE, ERR_CODE
    );

endinterface

// File: rtl/u409_cia_edge_sync.sv
// Brings CLKCIA into the CLK40 domain and emits a one-clock tick per rising
// edge, suppressed until three clocks after reset so a high level is not an edge.
`timescale 1ns/100ps
module u409_cia_edge_sync (
    input  logic CLK40,
    input  logic TS_RESET,
    input  logic CLKCIA,
    output logic tick
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [1:0] prime_cnt;
    logic       prime;

    assign prime = (prime_cnt == 2'd3);

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would collapse the synchroniser chain into one stage.
    always_ff @(posedge CLK40 or posedge TS_RESET) begin
        if (TS_RESET) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            prev      <= 1'b0;
            prime_cnt <= 2'd0;
        end else begin
            sync1 <= CLKCIA;
            sync2 <= sync1;
            prev  <= sync2;
            if (!prime) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign tick = prime & sync2 & ~prev;

endmodule

// File: rtl/u409_bus_watchdog.sv
// U409 bus-cycle watchdog: arms on nTS, picks a per-space response budget and
// raises a one-clock nTEA when no target terminates the cycle in time.
`timescale 1ns/100ps
module u409_bus_watchdog
    import u409_pkg::*;
#(
    parameter int CTR_W        = DEF_CTR_W,
    parameter int ROM_BUDGET   = DEF_ROM_BUDGET,
    parameter int AGNUS_BUDGET = DEF_AGNUS_BUDGET,
    parameter int LOCAL_BUDGET = DEF_LOCAL_BUDGET,
    parameter int CIA_BUDGET   = DEF_CIA_BUDGET,
    parameter int UNMAP_DELAY  = DEF_UNMAP_DELAY,
    parameter int HOLDOFF      = DEF_HOLDOFF
) (
    input  logic              CLK40,
    input  logic              TS_RESET,
    input  logic              CLKCIA,
    u409_bus_watchdog_if.slave bus
);

    if (CTR_W < 1 || CTR_W > 31) begin : g_bad_ctr_w
        $error("u409_bus_watchdog: CTR_W must be in 1..31");
    end
    if (!param_in_range(ROM_BUDGET, CTR_W)   || !param_in_range(AGNUS_BUDGET, CTR_W) ||
        !param_in_range(LOCAL_BUDGET, CTR_W) || !param_in_range(CIA_BUDGET, CTR_W)   ||
        !param_in_range(UNMAP_DELAY, CTR_W)  || !param_in_range(HOLDOFF, CTR_W)) begin : g_bad_limits
        $error("u409_bus_watchdog: budgets, UNMAP_DELAY and HOLDOFF must be in 1..2^CTR_W-1");
    end

    state_t           state;
    logic [CTR_W-1:0] cnt;
    logic [CTR_W-1:0] hold_cnt;
    logic             cia_mode;
    err_code_t        pending;
    logic             cia_tick;
    err_code_t        decode_code;
    logic [CTR_W-1:0] decode_load;

    u409_cia_edge_sync u_cia_sync (
        .CLK40   (CLK40),
        .TS_RESET(TS_RESET),
        .CLKCIA  (CLKCIA),
        .tick    (cia_tick)
    );

    // NOTE: every variable gets a default first so no path through the
    // block leaves it unassigned and infers a latch.
    always_comb begin
        decode_code = classify(bus.ROM_SPACE, bus.CIA_SPACE, bus.AGNUS_SPACE, bus.LOCAL_SPACE);
        decode_load = CTR_W'(UNMAP_DELAY);
        case (decode_code)
            ERR_ROM:   decode_load = CTR_W'(ROM_BUDGET);
            ERR_CIA:   decode_load = CTR_W'(CIA_BUDGET);
            ERR_AGNUS: decode_load = CTR_W'(AGNUS_BUDGET);
            ERR_LOCAL: decode_load = CTR_W'(LOCAL_BUDGET);
            default:   decode_load = CTR_W'(UNMAP_DELAY);
        endcase
    end

    // TS_RESET covers nTA as well as nRESET, so a normal termination lands here.
    always_ff @(posedge CLK40 or posedge TS_RESET) begin
        if (TS_RESET) begin
            state            <= IDLE;
            cnt              <= '0;
            hold_cnt         <= '0;
            cia_mode         <= 1'b0;
            pending          <= ERR_NONE;
            bus.nTEA         <= 1'b1;
            bus.CYCLE_ACTIVE <= 1'b0;
            bus.ERR_CODE     <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.nTS) begin
                        state            <= DECODE;
                        bus.CYCLE_ACTIVE <= 1'b1;
                    end
                end
                DECODE: begin
                    cnt      <= decode_load;
                    pending  <= decode_code;
                    cia_mode <= (decode_code == ERR_CIA);
                    state    <= COUNT;
                end
                COUNT: begin
                    if (cnt == '0) begin
                        state            <= TEA;
                        bus.nTEA         <= 1'b0;
                        bus.CYCLE_ACTIVE <= 1'b0;
                        bus.ERR_CODE     <= pending;
                    end else if (!cia_mode || cia_tick) begin
                        cnt <= cnt - CTR_W'(1);
                    end
                end
                TEA: begin
                    bus.nTEA <= 1'b1;
                    hold_cnt <= CTR_W'(HOLDOFF - 1);
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CTR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_tea_one_clock: assert property (@(posedge CLK40) disable iff (TS_RESET)
        !bus.nTEA |=> bus.nTEA);

    a_active_matches_state: assert property (@(posedge CLK40) disable iff (TS_RESET)
        bus.CYCLE_ACTIVE == (state inside {DECODE, COUNT}));

endmodule

// File: tb/tb_u409_bus_watchdog.sv
// Directed bench for u409_bus_watchdog: per-space timeouts, abort by TS_RESET,
// ignored nTS, and CIA tick counting with CLKCIA high at reset release.
`timescale 1ns/100ps
module tb_u409_bus_watchdog;
    import u409_pkg::*;

    localparam int ROM_B   = 64;
    localparam int AGNUS_B = 255;
    localparam int LOCAL_B = 255;
    localparam int CIA_B   = 24;
    localparam int UNMAP_D = 2;

    logic CLK40    = 1'b0;
    logic CLKCIA   = 1'b0;
    logic TS_RESET = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    int   cia_rises  = 0;
    int   since_rise = 0;
    logic cia_prev   = 1'b0;

    u409_bus_watchdog_if bus ();

    u409_bus_watchdog dut (
        .CLK40   (CLK40),
        .TS_RESET(TS_RESET),
        .CLKCIA  (CLKCIA),
        .bus     (bus)
    );

    always #12.5 CLK40 = ~CLK40;

    // ~716 kHz, phase chosen so its edges never coincide with CLK40 edges
    initial begin
        #0.3;
        forever #698 CLKCIA = ~CLKCIA;
    end

    // Counts CLKCIA rises and CLK40 edges since the latest rise
    always @(posedge CLK40) begin
        if (CLKCIA && !cia_prev) begin
            cia_rises  = cia_rises + 1;
            since_rise = 1;
        end else begin
            since_rise = since_rise + 1;
        end
        cia_prev = CLKCIA;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench stopped by time limit");
    end

    task automatic clear_inputs();
        bus.nTS         = 1'b1;
        bus.ROM_SPACE   = 1'b0;
        bus.CIA_SPACE   = 1'b0;
        bus.AGNUS_SPACE = 1'b0;
        bus.LOCAL_SPACE = 1'b0;
    endtask

    // flags = {ROM, CIA, AGNUS, LOCAL}; returns just after the nTS sampling edge
    task automatic start_cycle(input logic [3:0] flags);
        @(negedge CLK40);
        bus.nTS = 1'b0;
        @(negedge CLK40);
        bus.nTS = 1'b1;
        {bus.ROM_SPACE, bus.CIA_SPACE, bus.AGNUS_SPACE, bus.LOCAL_SPACE} = flags;
    endtask

    // n = rising edges until nTEA is seen low, -1 if the limit expires
    task automatic wait_tea(input int limit, output int n, output logic ca_before);
        logic ca_prev;
        n         = 0;
        ca_before = 1'b0;
        ca_prev   = bus.CYCLE_ACTIVE;
        while (n < limit) begin
            @(posedge CLK40);
            n++;
            @(negedge CLK40);
            if (!bus.nTEA) begin
                ca_before = ca_prev;
                return;
            end
            ca_prev = bus.CYCLE_ACTIVE;
        end
        n = -1;
    endtask

    task automatic finish_cycle();
        repeat (4) @(negedge CLK40);
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        TS_RESET = 1'b1;
        #40;
        tests_run++;
        if (bus.nTEA !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ntea: got %b expected 1", bus.nTEA);
        end
        tests_run++;
        if (bus.CYCLE_ACTIVE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_active: got %b expected 0", bus.CYCLE_ACTIVE);
        end
        tests_run++;
        if (bus.ERR_CODE !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_err: got %0d expected 0", bus.ERR_CODE);
        end
        tests_run++;
        if (dut.state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        @(negedge CLK40);
        TS_RESET = 1'b0;
        repeat (5) @(negedge CLK40);
        tests_run++;
        if (bus.CYCLE_ACTIVE !== 1'b0 || bus.nTEA !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_quiet: active=%b ntea=%b expected 0/1", bus.CYCLE_ACTIVE, bus.nTEA);
        end
    endtask

    task automatic test_rom_timeout();
        int   n;
        logic ca_before;
        start_cycle(4'b1000);
        wait_tea(200, n, ca_before);
        tests_run++;
        if (n !== ROM_B + 2) begin
            tests_failed++;
            $display("FAIL rom_latency: got %0d clocks expected %0d", n, ROM_B + 2);
        end
        tests_run++;
        if (bus.ERR_CODE !== 3'd3) begin
            tests_failed++;
            $display("FAIL rom_err: got %0d expected 3", bus.ERR_CODE);
        end
        tests_run++;
        if (ca_before !== 1'b1 || bus.CYCLE_ACTIVE !== 1'b0) begin
            tests_failed++;
            $display("FAIL rom_active_fall: before=%b at_tea=%b expected 1/0", ca_before, bus.CYCLE_ACTIVE);
        end
        @(negedge CLK40);
        tests_run++;
        if (bus.nTEA !== 1'b1) begin
            tests_failed++;
            $display("FAIL rom_tea_width: got %b one clock later expected 1", bus.nTEA);
        end
        tests_run++;
        if (bus.ERR_CODE !== 3'd3) begin
            tests_failed++;
            $display("FAIL rom_err_held: got %0d expected 3", bus.ERR_CODE);
        end
        finish_cycle();
    endtask

    task automatic test_abort();
        int   n;
        logic ca_before;
        logic seen_tea;
        start_cycle(4'b0010);
        repeat (9) @(negedge CLK40);
        TS_RESET = 1'b1;
        @(negedge CLK40);
        TS_RESET = 1'b0;
        tests_run++;
        if (dut.state !== IDLE || bus.CYCLE_ACTIVE !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: state=%0d active=%b expected %0d/0", dut.state, bus.CYCLE_ACTIVE, IDLE);
        end
        seen_tea = 1'b0;
        repeat (300) begin
            @(negedge CLK40);
            if (!bus.nTEA) seen_tea = 1'b1;
        end
        tests_run++;
        if (seen_tea !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_tea: nTEA low seen=%b expected 0", seen_tea);
        end
        tests_run++;
        if (bus.ERR_CODE !== 3'd0) begin
            tests_failed++;
            $display("FAIL abort_err: got %0d expected 0", bus.ERR_CODE);
        end
        start_cycle(4'b0010);
        wait_tea(400, n, ca_before);
        tests_run++;
        if (n !== AGNUS_B + 2 || bus.ERR_CODE !== 3'd5) begin
            tests_failed++;
            $display("FAIL agnus_rearm: got %0d clocks code %0d expected %0d code 5", n, bus.ERR_CODE, AGNUS_B + 2);
        end
        finish_cycle();
    endtask

    task automatic test_decode_errors();
        int   n;
        logic ca_before;
        start_cycle(4'b0000);
        wait_tea(50, n, ca_before);
        tests_run++;
        if (n !== UNMAP_D + 2 || bus.ERR_CODE !== 3'd1) begin
            tests_failed++;
            $display("FAIL unmapped: got %0d clocks code %0d expected %0d code 1", n, bus.ERR_CODE, UNMAP_D + 2);
        end
        finish_cycle();
        start_cycle(4'b1010);
        wait_tea(50, n, ca_before);
        tests_run++;
        if (n !== UNMAP_D + 2 || bus.ERR_CODE !== 3'd2) begin
            tests_failed++;
            $display("FAIL conflict: got %0d clocks code %0d expected %0d code 2", n, bus.ERR_CODE, UNMAP_D + 2);
        end
        finish_cycle();
        start_cycle(4'b0001);
        wait_tea(400, n, ca_before);
        tests_run++;
        if (n !== LOCAL_B + 2 || bus.ERR_CODE !== 3'd6) begin
            tests_failed++;
            $display("FAIL local: got %0d clocks code %0d expected %0d code 6", n, bus.ERR_CODE, LOCAL_B + 2);
        end
        finish_cycle();
    endtask

    task automatic test_ignore_nts();
        int   n;
        logic ca_before;
        logic seen_activity;
        start_cycle(4'b1000);
        repeat (20) @(negedge CLK40);
        bus.nTS = 1'b0;
        @(negedge CLK40);
        bus.nTS = 1'b1;
        wait_tea(200, n, ca_before);
        // 21 edges already consumed after the nTS sample
        tests_run++;
        if (n !== ROM_B + 2 - 21) begin
            tests_failed++;
            $display("FAIL ignore_count_nts: got %0d clocks expected %0d", n, ROM_B + 2 - 21);
        end
        @(negedge CLK40);
        bus.nTS = 1'b0;
        @(negedge CLK40);
        bus.nTS = 1'b1;
        seen_activity = 1'b0;
        repeat (20) begin
            @(negedge CLK40);
            if (bus.CYCLE_ACTIVE || !bus.nTEA) seen_activity = 1'b1;
        end
        tests_run++;
        if (seen_activity !== 1'b0 || dut.state !== IDLE) begin
            tests_failed++;
            $display("FAIL ignore_hold_nts: activity=%b state=%0d expected 0/%0d", seen_activity, dut.state, IDLE);
        end
        clear_inputs();
    endtask

    task automatic test_tea_reset();
        int   n;
        logic ca_before;
        logic seen_tea;
        start_cycle(4'b0000);
        wait_tea(50, n, ca_before);
        tests_run++;
        if (n !== UNMAP_D + 2) begin
            tests_failed++;
            $display("FAIL tea_reset_setup: got %0d clocks expected %0d", n, UNMAP_D + 2);
        end
        #2 TS_RESET = 1'b1;
        #1;
        tests_run++;
        if (bus.nTEA !== 1'b1 || bus.ERR_CODE !== 3'd0) begin
            tests_failed++;
            $display("FAIL tea_async_release: ntea=%b code=%0d expected 1/0", bus.nTEA, bus.ERR_CODE);
        end
        @(posedge CLK40);
        #1;
        tests_run++;
        if (dut.state !== IDLE || bus.CYCLE_ACTIVE !== 1'b0) begin
            tests_failed++;
            $display("FAIL tea_reset_idle: state=%0d active=%b expected %0d/0", dut.state, bus.CYCLE_ACTIVE, IDLE);
        end
        @(negedge CLK40);
        TS_RESET = 1'b0;
        clear_inputs();
        seen_tea = 1'b0;
        repeat (8) begin
            @(negedge CLK40);
            if (!bus.nTEA) seen_tea = 1'b1;
        end
        tests_run++;
        if (seen_tea !== 1'b0) begin
            tests_failed++;
            $display("FAIL tea_no_retry: nTEA low seen=%b expected 0", seen_tea);
        end
    endtask

    task automatic test_cia();
        int   n;
        int   base;
        logic ca_before;
        @(posedge CLKCIA);
        @(negedge CLK40);
        TS_RESET      = 1'b1;
        bus.nTS       = 1'b0;
        bus.CIA_SPACE = 1'b1;
        @(negedge CLK40);
        // CLKCIA is high here; the cycle arms on the first edge after release
        TS_RESET = 1'b0;
        base     = cia_rises;
        @(negedge CLK40);
        bus.nTS = 1'b1;
        wait_tea(3000, n, ca_before);
        tests_run++;
        if (n === -1) begin
            tests_failed++;
            $display("FAIL cia_timeout: nTEA not seen within %0d clocks", 3000);
        end
        tests_run++;
        if (cia_rises - base !== CIA_B) begin
            tests_failed++;
            $display("FAIL cia_tick_count: got %0d rises expected %0d", cia_rises - base, CIA_B);
        end
        tests_run++;
        if (since_rise !== 4) begin
            tests_failed++;
            $display("FAIL cia_tea_delay: got %0d clocks after rise expected 4", since_rise);
        end
        tests_run++;
        if (bus.ERR_CODE !== 3'd4) begin
            tests_failed++;
            $display("FAIL cia_err: got %0d expected 4", bus.ERR_CODE);
        end
        finish_cycle();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_rom_timeout();
        test_abort();
        test_decode_errors();
        test_ignore_nts();
        test_tea_reset();
        test_cia();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
